imu_accel_sequencer: RTL and testbench

- Sequences the i2c_master to configure the IMU once and then periodically burst-read the six acceleration registers (ACCX/Y/Z LSB/MSB).
- Assembles the bytes into three 16-bit signed samples and publishes them atomically with a one-cycle valid strobe.
- Sits between the top level (simp) and i2c_master, and owns every i2c_master control input.
- Detects transactions that never complete, using a done-timeout watchdog.

---
 rtl/imu_accel_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_imu_accel_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_accel_sequencer.sv
// Drives an i2c_master: writes the IMU config register once, then periodically
// burst-reads six acceleration bytes and publishes them as three signed samples.
module imu_accel_sequencer #(
    parameter logic [6:0] IMU_ADDR       = 7'h68,
    parameter logic [6:0] ACC_BASE_ADDR  = 7'h12,
    parameter logic [6:0] CFG_REG        = 7'h7E,
    parameter logic [7:0] CFG_DATA       = 8'h11,
    parameter int unsigned SAMPLE_PERIOD  = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic        o_m_start,
    output logic        o_m_read_write,
    output logic [6:0]  o_m_slave_addr,
    output logic [6:0]  o_m_reg_addr,
    output logic [7:0]  o_m_data_in,
    input  logic [7:0]  i_m_data_out,
    input  logic        i_m_busy,
    input  logic        i_m_done,
    output logic [15:0] o_acc_x,
    output logic [15:0] o_acc_y,
    output logic [15:0] o_acc_z,
    output logic        o_sample_valid,
    output logic        o_init_done,
    output logic        o_err,
    output logic [7:0]  o_err_count
);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [PW-1:0] PER_ONE  = PW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_INIT_ISSUE  = 3'd1,
        S_INIT_WAIT   = 3'd2,
        S_RD_ISSUE    = 3'd3,
        S_RD_WAIT     = 3'd4,
        S_PUBLISH     = 3'd5,
        S_WAIT_PERIOD = 3'd6
    } state_t;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [PW-1:0]    r_per_cnt;
    logic [TW-1:0]    r_tmo_cnt;
    logic [5:0][7:0]  r_bytes;
    logic             r_m_start;
    logic             r_m_read_write;
    logic [6:0]       r_m_reg_addr;
    logic [7:0]       r_m_data_in;
    logic [15:0]      r_acc_x;
    logic [15:0]      r_acc_y;
    logic [15:0]      r_acc_z;
    logic             r_sample_valid;
    logic             r_init_done;
    logic             r_err;
    logic [7:0]       r_err_count;

    // A done coinciding with our own start pulse belongs to an older transaction.
    logic w_done;
    logic w_tmo;
    assign w_done = i_m_done & ~r_m_start;
    assign w_tmo  = (r_tmo_cnt == TMO_LAST);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'h01;
    endfunction

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_idx          <= 3'd0;
            r_per_cnt      <= '0;
            r_tmo_cnt      <= '0;
            r_bytes        <= 48'h0;
            r_m_start      <= 1'b0;
            r_m_read_write <= 1'b0;
            r_m_reg_addr   <= 7'h00;
            r_m_data_in    <= 8'h00;
            r_acc_x        <= 16'h0000;
            r_acc_y        <= 16'h0000;
            r_acc_z        <= 16'h0000;
            r_sample_valid <= 1'b0;
            r_init_done    <= 1'b0;
            r_err          <= 1'b0;
            r_err_count    <= 8'h00;
        end else begin
            r_m_start      <= 1'b0;
            r_sample_valid <= 1'b0;
            r_err          <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state <= r_init_done ? S_RD_ISSUE : S_INIT_ISSUE;
                    end
                end
                S_INIT_ISSUE: begin
                    r_m_read_write <= 1'b0;
                    r_m_reg_addr   <= CFG_REG;
                    r_m_data_in    <= CFG_DATA;
                    if (!i_m_busy) begin
                        r_m_start <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_INIT_WAIT;
                    end
                end
                S_INIT_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
                    if (w_done) begin
                        r_init_done <= 1'b1;
                        r_state     <= S_WAIT_PERIOD;
                    end else if (w_tmo) begin
                        r_err       <= 1'b1;
                        r_err_count <= sat_inc(r_err_count);
                        r_state     <= S_WAIT_PERIOD;
                    end
                end
                S_RD_ISSUE: begin
                    r_m_read_write <= 1'b1;
                    r_m_reg_addr   <= ACC_BASE_ADDR + {4'h0, r_idx};
                    if (!i_m_busy) begin
                        r_m_start <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
                    if (w_done) begin
                        if (r_idx == 3'd5) begin
                            // Last byte goes straight to the outputs to meet the one-cycle latency.
                            r_acc_x        <= {r_bytes[1], r_bytes[0]};
                            r_acc_y        <= {r_bytes[3], r_bytes[2]};
                            r_acc_z        <= {i_m_data_out, r_bytes[4]};
                            r_sample_valid <= 1'b1;
                            r_state        <= S_PUBLISH;
                        end else begin
                            r_bytes[r_idx] <= i_m_data_out;
                            r_idx          <= r_idx + 3'd1;
                            r_state        <= S_RD_ISSUE;
                        end
                    end else if (w_tmo) begin
                        r_err       <= 1'b1;
                        r_err_count <= sat_inc(r_err_count);
                        r_bytes     <= 48'h0;
                        r_idx       <= 3'd0;
                        r_state     <= S_WAIT_PERIOD;
                    end
                end
                S_PUBLISH: begin
                    r_idx   <= 3'd0;
                    r_state <= S_WAIT_PERIOD;
                end
                S_WAIT_PERIOD: begin
                    if (!i_enable) begin
                        r_per_cnt <= '0;
                    end else if (r_per_cnt == PER_LAST) begin
                        r_per_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_per_cnt <= r_per_cnt + PER_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_m_start      = r_m_start;
    assign o_m_read_write = r_m_read_write;
    assign o_m_slave_addr = IMU_ADDR;
    assign o_m_reg_addr   = r_m_reg_addr;
    assign o_m_data_in    = r_m_data_in;
    assign o_acc_x        = r_acc_x;
    assign o_acc_y        = r_acc_y;
    assign o_acc_z        = r_acc_z;
    assign o_sample_valid = r_sample_valid;
    assign o_init_done    = r_init_done;
    assign o_err          = r_err;
    assign o_err_count    = r_err_count;
endmodule

// File: tb/tb_imu_accel_sequencer.sv
// Bench for imu_accel_sequencer: an i2c_master BFM, a transaction/publish monitor
// and scenario tasks comparing against expectations built from returned bytes.
module tb_imu_accel_sequencer;
    localparam int SP  = 16;
    localparam int TMO = 64;
    localparam int DLY = 20;

    logic        clk = 1'b0;
    logic        rst, enable, m_busy, m_done;
    logic [7:0]  m_data_out;
    logic        m_start, m_rw;
    logic [6:0]  m_slave, m_reg;
    logic [7:0]  m_din;
    logic [15:0] acc_x, acc_y, acc_z;
    logic        sample_valid, init_done, err;
    logic [7:0]  err_count;

    imu_accel_sequencer #(.SAMPLE_PERIOD(SP), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable),
        .o_m_start(m_start), .o_m_read_write(m_rw), .o_m_slave_addr(m_slave),
        .o_m_reg_addr(m_reg), .o_m_data_in(m_din), .i_m_data_out(m_data_out),
        .i_m_busy(m_busy), .i_m_done(m_done),
        .o_acc_x(acc_x), .o_acc_y(acc_y), .o_acc_z(acc_z),
        .o_sample_valid(sample_valid), .o_init_done(init_done),
        .o_err(err), .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // BFM configuration, written by the scenario tasks
    logic [7:0] bfm_bytes [6];
    int  bfm_drop_idx     = -1;
    int  bfm_busy_pre_idx = -1;
    bit  bfm_drop_all     = 1'b0;

    // i2c_master BFM: done DLY cycles after start, or never when told to drop
    initial begin : bfm
        int phase, cnt, idx;
        bit ignore;
        m_busy = 1'b0; m_done = 1'b0; m_data_out = 8'h00;
        phase = 0; cnt = 0; idx = 0; ignore = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0;
            if (phase == 0) begin
                if (m_start === 1'b1) begin
                    m_busy = 1'b1; cnt = 0; phase = 1;
                    idx = int'(m_reg) - 'h12;
                    ignore = bfm_drop_all || (m_rw && idx == bfm_drop_idx);
                end
            end else if (phase == 1) begin
                cnt++;
                if (!ignore && cnt == DLY) begin
                    m_done = 1'b1;
                    m_data_out = (m_rw && idx >= 0 && idx < 6) ? bfm_bytes[idx] : 8'h00;
                    if (m_rw && idx + 1 == bfm_busy_pre_idx) begin
                        phase = 2; cnt = 0;
                    end else begin
                        m_busy = 1'b0; phase = 0;
                    end
                end else if (ignore && cnt == TMO + 2) begin
                    m_busy = 1'b0; phase = 0;
                end
            end else begin
                cnt++;
                if (cnt == 10) begin
                    m_busy = 1'b0; phase = 0;
                end
            end
        end
    end

    typedef struct { int cyc; logic rw; logic [6:0] ra; logic [7:0] wd; } start_t;
    typedef struct { int cyc; int lat; logic [15:0] x; logic [15:0] y; logic [15:0] z; } pub_t;
    start_t start_q[$];
    pub_t   pub_q[$];
    int     err_q[$];
    int     cyc = 0;
    int     last_done = 0;
    int     busy_viol = 0;
    int     stab_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log transactions, publishes, errors and handshake violations
    initial begin : mon
        start_t cur;
        pub_t   p;
        logic   prev_busy, in_txn;
        prev_busy = 1'b0; in_txn = 1'b0;
        cur.cyc = 0; cur.rw = 1'b0; cur.ra = 7'h00; cur.wd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                in_txn = 1'b0;
            end else if (m_start === 1'b1) begin
                if (prev_busy) busy_viol++;
                cur.cyc = cyc; cur.rw = m_rw; cur.ra = m_reg; cur.wd = m_din;
                start_q.push_back(cur);
                in_txn = 1'b1;
            end else if (in_txn) begin
                if (m_rw !== cur.rw || m_reg !== cur.ra || m_din !== cur.wd) stab_viol++;
                if (m_done || err) in_txn = 1'b0;
            end
            if (m_done === 1'b1) last_done = cyc;
            if (err === 1'b1) err_q.push_back(cyc);
            if (sample_valid === 1'b1) begin
                p.cyc = cyc; p.lat = cyc - last_done; p.x = acc_x; p.y = acc_y; p.z = acc_z;
                pub_q.push_back(p);
            end
            prev_busy = m_busy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_pub(input int n, input int budget, output bit ok);
        int k = 0;
        while (pub_q.size() < n && k < budget) begin step(1); k++; end
        ok = (pub_q.size() >= n);
    endtask

    task automatic wait_start_reg(input logic [6:0] ra, input int s0, input int budget, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (!ok && k < budget) begin
            step(1); k++;
            if (start_q.size() > s0 && start_q[$].ra == ra) ok = 1'b1;
        end
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 6; i++) bfm_bytes[i] = 8'($urandom);
    endtask

    // Verifies a finished burst: six ordered reads from s0 and the published words
    task automatic check_burst(input string tag, input int s0, input int p0);
        logic [15:0] ex, ey, ez;
        ex = {bfm_bytes[1], bfm_bytes[0]};
        ey = {bfm_bytes[3], bfm_bytes[2]};
        ez = {bfm_bytes[5], bfm_bytes[4]};
        n_checks++;
        if (start_q.size() - s0 !== 6) $display("FAIL %s_nstarts got %0d exp 6", tag, start_q.size() - s0);
        else n_pass++;
        for (int i = 0; i < 6 && s0 + i < start_q.size(); i++) begin
            n_checks++;
            if ({start_q[s0+i].rw, start_q[s0+i].ra} !== {1'b1, 7'h12 + 7'(i)})
                $display("FAIL %s_rd%0d got rw=%0b reg=%h exp rw=1 reg=%h", tag, i,
                         start_q[s0+i].rw, start_q[s0+i].ra, 7'h12 + 7'(i));
            else n_pass++;
        end
        n_checks++;
        if ({pub_q[p0].x, pub_q[p0].y, pub_q[p0].z} !== {ex, ey, ez})
            $display("FAIL %s_acc got %h %h %h exp %h %h %h", tag, pub_q[p0].x, pub_q[p0].y, pub_q[p0].z, ex, ey, ez);
        else n_pass++;
        n_checks++;
        if (pub_q[p0].lat !== 1) $display("FAIL %s_latency got %0d exp 1", tag, pub_q[p0].lat);
        else n_pass++;
        step(2);
        n_checks++;
        if (pub_q.size() !== p0 + 1) $display("FAIL %s_valid_width got %0d pulses exp 1", tag, pub_q.size() - p0);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        step(3);
        n_checks++;
        if (m_start !== 1'b0) $display("FAIL reset_start got %0b exp 0", m_start); else n_pass++;
        n_checks++;
        if ({acc_x, acc_y, acc_z} !== 48'h0) $display("FAIL reset_acc got %h exp 0", {acc_x, acc_y, acc_z}); else n_pass++;
        n_checks++;
        if ({sample_valid, init_done, err, err_count} !== 11'h0)
            $display("FAIL reset_status got %h exp 0", {sample_valid, init_done, err, err_count}); else n_pass++;
        n_checks++;
        if (m_slave !== 7'h68) $display("FAIL reset_slave got %h exp 68", m_slave); else n_pass++;
        n_checks++;
        if ({m_rw, m_reg, m_din} !== 16'h0) $display("FAIL reset_cmd got %h exp 0", {m_rw, m_reg, m_din}); else n_pass++;
        rst = 1'b0;
        step(40);
        n_checks++;
        if (start_q.size() !== 0) $display("FAIL idle_no_start got %0d starts exp 0", start_q.size()); else n_pass++;
    endtask

    task automatic test_init_and_first_burst();
        int s0, p0;
        bit ok;
        s0 = start_q.size(); p0 = pub_q.size();
        bfm_bytes = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h80};
        enable = 1'b1;
        wait_pub(p0 + 1, 2000, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL first_burst_timeout got %0d publishes exp 1", pub_q.size() - p0);
        end else begin
            n_pass++;
            n_checks++;
            if ({start_q[s0].rw, start_q[s0].ra, start_q[s0].wd} !== {1'b0, 7'h7E, 8'h11})
                $display("FAIL init_write got rw=%0b reg=%h data=%h exp 0/7e/11", start_q[s0].rw, start_q[s0].ra, start_q[s0].wd);
            else n_pass++;
            n_checks++;
            if (init_done !== 1'b1) $display("FAIL init_done got %0b exp 1", init_done); else n_pass++;
            n_checks++;
            if (start_q[s0+1].cyc - start_q[s0].cyc < DLY + SP)
                $display("FAIL period_gap got %0d exp >= %0d", start_q[s0+1].cyc - start_q[s0].cyc, DLY + SP);
            else n_pass++;
            n_checks++;
            if ({acc_x, acc_y, acc_z} !== {16'h1234, 16'hABCD, 16'h8000})
                $display("FAIL fixed_acc got %h %h %h exp 1234 abcd 8000", acc_x, acc_y, acc_z);
            else n_pass++;
            check_burst("first", s0 + 1, p0);
        end
    endtask

    task automatic test_random_bursts();
        int s0, p0;
        bit ok;
        for (int b = 0; b < 4; b++) begin
            rand_bytes();
            s0 = start_q.size(); p0 = pub_q.size();
            wait_pub(p0 + 1, 2000, ok);
            n_checks++;
            if (!ok) $display("FAIL rand_burst%0d_timeout got 0 publishes exp 1", b);
            else begin n_pass++; check_burst("rand", s0, p0); end
        end
    endtask

    task automatic test_busy_hold();
        int s0, p0;
        bit ok;
        rand_bytes();
        bfm_busy_pre_idx = 3;
        s0 = start_q.size(); p0 = pub_q.size();
        wait_pub(p0 + 1, 2000, ok);
        bfm_busy_pre_idx = -1;
        n_checks++;
        if (!ok) begin
            $display("FAIL busy_timeout got 0 publishes exp 1");
        end else begin
            n_pass++;
            check_burst("busy", s0, p0);
            n_checks++;
            if (start_q[s0+3].cyc - start_q[s0+2].cyc < DLY + 10)
                $display("FAIL busy_gap got %0d exp >= %0d", start_q[s0+3].cyc - start_q[s0+2].cyc, DLY + 10);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int s0, p0, e0, s1, k;
        logic [47:0] acc_before;
        bit ok;
        rand_bytes();
        bfm_drop_idx = 4;
        acc_before = {acc_x, acc_y, acc_z};
        s0 = start_q.size(); p0 = pub_q.size(); e0 = err_q.size();
        k = 0;
        while (err_q.size() == e0 && k < 2000) begin step(1); k++; end
        n_checks++;
        if (err_q.size() == e0) begin
            $display("FAIL timeout_no_err got 0 err pulses exp 1");
        end else begin
            n_pass++;
            n_checks++;
            if (start_q[$].ra !== 7'h16) $display("FAIL timeout_reg got %h exp 16", start_q[$].ra); else n_pass++;
            n_checks++;
            if (err_q[e0] - start_q[$].cyc !== TMO)
                $display("FAIL timeout_delay got %0d exp %0d", err_q[e0] - start_q[$].cyc, TMO);
            else n_pass++;
            n_checks++;
            if (err_count !== 8'd1) $display("FAIL timeout_count got %0d exp 1", err_count); else n_pass++;
            n_checks++;
            if ({acc_x, acc_y, acc_z} !== acc_before || pub_q.size() !== p0)
                $display("FAIL timeout_acc got %h pubs=%0d exp %h pubs=%0d", {acc_x, acc_y, acc_z}, pub_q.size(), acc_before, p0);
            else n_pass++;
            step(3);
            n_checks++;
            if (err_q.size() !== e0 + 1) $display("FAIL timeout_err_width got %0d exp 1", err_q.size() - e0); else n_pass++;
        end
        bfm_drop_idx = -1;
        rand_bytes();
        s1 = start_q.size(); p0 = pub_q.size();
        wait_pub(p0 + 1, 2000, ok);
        n_checks++;
        if (!ok) $display("FAIL after_timeout_no_pub got 0 publishes exp 1");
        else begin n_pass++; check_burst("retry", s1, p0); end
    endtask

    task automatic test_enable_drop();
        int s0, p0, s1;
        bit ok;
        rand_bytes();
        s0 = start_q.size(); p0 = pub_q.size();
        wait_start_reg(7'h13, s0, 2000, ok);
        enable = 1'b0;
        wait_pub(p0 + 1, 2000, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL endrop_no_pub got 0 publishes exp 1");
        end else begin
            n_pass++;
            check_burst("endrop", s0, p0);
            s1 = start_q.size();
            step(300);
            n_checks++;
            if (start_q.size() !== s1) $display("FAIL endrop_parked got %0d starts exp 0", start_q.size() - s1); else n_pass++;
            n_checks++;
            if (err_count !== 8'd1) $display("FAIL endrop_errcnt got %0d exp 1", err_count); else n_pass++;
            enable = 1'b1;
            wait_start_reg(7'h12, s1, 100, ok);
            n_checks++;
            if (!ok || start_q[s1].rw !== 1'b1 || start_q[s1].ra !== 7'h12)
                $display("FAIL endrop_resume got ok=%0b exp read of reg 12", ok);
            else n_pass++;
            wait_pub(p0 + 2, 2000, ok);
        end
    endtask

    task automatic test_reset_mid_burst();
        int s0, p0, s1;
        bit ok;
        rand_bytes();
        s0 = start_q.size();
        wait_start_reg(7'h14, s0, 2000, ok);
        step(5);
        rst = 1'b1;
        step(1);
        n_checks++;
        if ({m_start, sample_valid, init_done, err, err_count} !== 12'h0)
            $display("FAIL midrst_status got %h exp 0", {m_start, sample_valid, init_done, err, err_count});
        else n_pass++;
        n_checks++;
        if ({acc_x, acc_y, acc_z, m_rw, m_reg, m_din} !== 64'h0)
            $display("FAIL midrst_outputs got %h exp 0", {acc_x, acc_y, acc_z, m_rw, m_reg, m_din});
        else n_pass++;
        n_checks++;
        if (m_slave !== 7'h68) $display("FAIL midrst_slave got %h exp 68", m_slave); else n_pass++;
        rst = 1'b0;
        s1 = start_q.size(); p0 = pub_q.size();
        wait_start_reg(7'h7E, s1, 300, ok);
        n_checks++;
        if (!ok || start_q[s1].rw !== 1'b0 || start_q[s1].wd !== 8'h11)
            $display("FAIL midrst_reinit got ok=%0b exp write 7e/11 first", ok);
        else n_pass++;
        wait_pub(p0 + 1, 2000, ok);
        n_checks++;
        if (!ok) $display("FAIL midrst_no_pub got 0 publishes exp 1");
        else begin n_pass++; check_burst("midrst", s1 + 1, p0); end
    endtask

    task automatic test_err_saturation();
        int e0, p0, k;
        bfm_drop_all = 1'b1;
        e0 = err_q.size(); p0 = pub_q.size();
        k = 0;
        while (err_q.size() < e0 + 300 && k < 40000) begin step(1); k++; end
        bfm_drop_all = 1'b0;
        n_checks++;
        if (err_q.size() - e0 !== 300) $display("FAIL sat_err_pulses got %0d exp 300", err_q.size() - e0); else n_pass++;
        n_checks++;
        if (err_count !== 8'd255) $display("FAIL sat_count got %0d exp 255", err_count); else n_pass++;
        n_checks++;
        if (pub_q.size() !== p0) $display("FAIL sat_no_pub got %0d exp 0", pub_q.size() - p0); else n_pass++;
    endtask

    task automatic test_handshake_rules();
        n_checks++;
        if (busy_viol !== 0) $display("FAIL start_while_busy got %0d exp 0", busy_viol); else n_pass++;
        n_checks++;
        if (stab_viol !== 0) $display("FAIL cmd_stability got %0d exp 0", stab_viol); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        for (int i = 0; i < 6; i++) bfm_bytes[i] = 8'h00;
        test_reset();
        test_init_and_first_burst();
        test_random_bursts();
        test_busy_hold();
        test_timeout();
        test_enable_drop();
        test_reset_mid_burst();
        test_err_saturation();
        test_handshake_rules();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
